led_seq_ctrl: RTL and testbench

Controller that sequences the 8-bit LED shift datapath. It owns the tick prescaler, the pattern mode state machine and the LED register. A debounced push-button steps through five display modes. A one-cycle `tick` strobe marks every pattern step so the top level and benches can synchronise to it.

---
 rtl/led_seq_pkg.sv | 34 +++
 rtl/led_seq_ctrl_tick_prescaler.sv | 42 ++++
 rtl/led_seq_ctrl.sv | 115 +++++++++++
 tb/tb_led_seq_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared definitions for the LED sequencer.
//   - mode codes (OFF, SHL, SHR, BOUNCE, FILL) and the mode-code width
//   - bounce direction type
//   - next_mode(): mode stepping order with the wrap from FILL back to OFF
package led_seq_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF    = 3'd0,
        MODE_SHL    = 3'd1,
        MODE_SHR    = 3'd2,
        MODE_BOUNCE = 3'd3,
        MODE_FILL   = 3'd4
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    // Codes 5..7 never occur; if they ever do, they behave like OFF,
    // so the next press takes the display to SHL.
    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_SHL:    next_mode = MODE_SHR;
            MODE_SHR:    next_mode = MODE_BOUNCE;
            MODE_BOUNCE: next_mode = MODE_FILL;
            MODE_FILL:   next_mode = MODE_OFF;
            default:     next_mode = MODE_SHL;
        endcase
    endfunction

endpackage

// File: rtl/led_seq_ctrl_tick_prescaler.sv
// tick_prescaler: free-running 0..DIV-1 counter that paces the pattern steps.
//   clk   in   system clock
//   rst_n in   asynchronous active-low reset
//   en    in   count enable; when low the counter holds
//   clr   in   synchronous clear to 0 (wins over counting)
//   step  out  combinational: high for the last count of a period while en=1
module tick_prescaler #(
    parameter int DIV   = 25_000_000,
    parameter int CNT_W = $clog2(DIV)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign step = en & (cnt_q == CNT_LAST);

endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: sequences an LED pattern register through five display modes.
//   clk   in   system clock
//   rst_n in   asynchronous active-low reset
//   en    in   run enable; low freezes prescaler and pattern
//   btn   in   debounced, clk-synchronous button level; rising edge = next mode
//   led   out  registered LED pattern
//   mode  out  registered mode code
//   tick  out  one-cycle strobe, high in the cycle a stepped led value appears
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 25_000_000,
    parameter int CNT_W = $clog2(DIV)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              btn,
    output logic [WIDTH-1:0]  led,
    output logic [MODE_W-1:0] mode,
    output logic              tick
);

    logic             btn_q, btn_d;
    mode_e            mode_q, mode_d;
    dir_e             dir_q, dir_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic             tick_q, tick_d;
    logic             btn_edge;
    logic             step;

    assign btn_edge = btn & ~btn_q;

    // A mode change restarts the step period so the first step of a new mode
    // comes a full DIV cycles after the seed appears.
    tick_prescaler #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (btn_edge),
        .step  (step)
    );

    always_comb begin
        btn_d  = btn;
        mode_d = mode_q;
        dir_d  = dir_q;
        led_d  = led_q;
        tick_d = 1'b0;

        if (btn_edge) begin
            // Mode change has priority; a coincident step is dropped.
            mode_d = next_mode(mode_q);
            dir_d  = DIR_LEFT;
            case (mode_d)
                MODE_SHL:    led_d = WIDTH'(1);
                MODE_SHR:    led_d = {1'b1, {(WIDTH-1){1'b0}}};
                MODE_BOUNCE: led_d = WIDTH'(1);
                default:     led_d = '0;
            endcase
        end else if (step) begin
            tick_d = 1'b1;
            case (mode_q)
                MODE_SHL: led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
                MODE_SHR: led_d = {led_q[0], led_q[WIDTH-1:1]};
                MODE_BOUNCE: begin
                    // Reverse at the ends without repeating the end value.
                    if (dir_q == DIR_LEFT) begin
                        if (led_q[WIDTH-1]) begin
                            dir_d = DIR_RIGHT;
                            led_d = led_q >> 1;
                        end else begin
                            led_d = led_q << 1;
                        end
                    end else begin
                        if (led_q[0]) begin
                            dir_d = DIR_LEFT;
                            led_d = WIDTH'(2);
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end
                end
                MODE_FILL: led_d = (&led_q) ? '0 : {led_q[WIDTH-2:0], 1'b1};
                default:   led_d = '0;
            endcase
        end
    end

    // btn_q resets high so a button held through reset is not seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q  <= 1'b1;
            mode_q <= MODE_OFF;
            dir_q  <= DIR_LEFT;
            led_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            btn_q  <= btn_d;
            mode_q <= mode_d;
            dir_q  <= dir_d;
            led_q  <= led_d;
            tick_q <= tick_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
module tb_led_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int DIV   = 4;
    localparam int TMO   = 20;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             btn;
    logic [WIDTH-1:0] led;
    logic [2:0]       mode;
    logic             tick;

    int n_checks;
    int n_errors;

    led_seq_ctrl #(
        .WIDTH (WIDTH),
        .DIV   (DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .btn   (btn),
        .led   (led),
        .mode  (mode),
        .tick  (tick)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("check %-14s ok (%0h)", tag, obs);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic press_btn();
        @(negedge clk) btn = 1'b1;
        @(negedge clk) btn = 1'b0;
    endtask

    // Returns the number of falling edges until tick is seen (TMO+1 on timeout).
    task automatic wait_tick(output int n);
        n = TMO + 1;
        for (int i = 1; i <= TMO; i++) begin
            @(negedge clk);
            if (tick) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic expect_ticks(input string tag, input int first_gap,
                                input logic [WIDTH-1:0] exp_q[$]);
        int n;
        foreach (exp_q[i]) begin
            wait_tick(n);
            check_eq({tag, "_gap"}, n, (i == 0) ? first_gap : DIV);
            check_eq({tag, "_led"}, led, exp_q[i]);
        end
    endtask

    initial begin
        int n;
        int seen;
        logic [WIDTH-1:0] bounce_q[$];
        logic [WIDTH-1:0] fill_q[$];
        logic [WIDTH-1:0] shl_q[$];
        logic [WIDTH-1:0] shr_q[$];

        bounce_q = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                     8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        fill_q   = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                     8'h00, 8'h01};
        shl_q    = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        shr_q    = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};

        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        btn   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_led", led, 8'h00);
        check_eq("rst_mode", mode, 3'd0);
        check_eq("rst_tick", tick, 1'b0);
        rst_n = 1'b1;
        en    = 1'b1;

        // Three presses -> BOUNCE, then a full bounce cycle
        repeat (3) press_btn();
        check_eq("bnc_mode", mode, 3'd3);
        check_eq("bnc_seed", led, 8'h01);
        expect_ticks("bnc", DIV, bounce_q);

        // FILL
        press_btn();
        check_eq("fill_mode", mode, 3'd4);
        check_eq("fill_seed", led, 8'h00);
        expect_ticks("fill", DIV, fill_q);

        // OFF still ticks, led stays 0
        press_btn();
        check_eq("off_mode", mode, 3'd0);
        wait_tick(n);
        check_eq("off_gap", n, DIV);
        check_eq("off_led", led, 8'h00);

        // SHL, then SHR
        press_btn();
        check_eq("shl_mode", mode, 3'd1);
        check_eq("shl_seed", led, 8'h01);
        expect_ticks("shl", DIV, shl_q);
        press_btn();
        check_eq("shr_mode", mode, 3'd2);
        check_eq("shr_seed", led, 8'h80);
        expect_ticks("shr", DIV, shr_q);

        // Back round to SHL, walk to 08, then freeze with cnt=2
        repeat (4) press_btn();
        check_eq("shl2_mode", mode, 3'd1);
        repeat (3) wait_tick(n);
        check_eq("pre_hold_led", led, 8'h08);
        repeat (2) @(negedge clk);
        en = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (tick) seen++;
        end
        check_eq("hold_ticks", seen, 0);
        check_eq("hold_led", led, 8'h08);
        en = 1'b1;
        wait_tick(n);
        check_eq("resume_gap", n, 2);
        check_eq("resume_led", led, 8'h10);

        // Button edge coincident with step: mode change wins
        repeat (3) @(negedge clk);
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
        check_eq("coll_mode", mode, 3'd2);
        check_eq("coll_led", led, 8'h80);
        check_eq("coll_tick", tick, 1'b0);
        wait_tick(n);
        check_eq("coll_gap", n, DIV);
        check_eq("coll_next", led, 8'h40);

        // Button held across reset release: no advance
        @(negedge clk);
        rst_n = 1'b0;
        btn   = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("held_mode", mode, 3'd0);
        btn = 1'b0;

        // Asynchronous reset mid-BOUNCE
        repeat (3) press_btn();
        check_eq("bnc2_mode", mode, 3'd3);
        repeat (2) wait_tick(n);
        check_eq("bnc2_led", led, 8'h04);
        #5;
        rst_n = 1'b0;
        #1;
        check_eq("arst_led", led, 8'h00);
        check_eq("arst_mode", mode, 3'd0);
        check_eq("arst_tick", tick, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(n);
        check_eq("post_rst_gap", n, DIV);
        check_eq("post_rst_led", led, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
